// File: rtl/lut_sweep_ctrl.sv
// lut_sweep_ctrl
//   Walks a small N_IN-input combinational LUT through every input vector,
//   samples its output after a settle delay, builds the observed truth table
//   and compares it against an expected table latched at start.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, overrides everything
//   start      one-cycle sweep request, honoured only when idle
//   expected   expected truth table (bit i = F for input index i)
//   f_in       LUT output F
//   lut_in     LUT input drive (MSB = first LUT input)
//   busy       high for the whole sweep
//   done       one-cycle completion pulse
//   truth      captured truth table
//   pass       truth matched expected; valid from done until next start
//   fail_count number of mismatching entries
//   first_fail lowest mismatching index, 0 when pass
module lut_sweep_ctrl #(
   parameter int unsigned N_IN       = 3,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [(1<<N_IN)-1:0]    expected,
   input  logic                    f_in,
   output logic [N_IN-1:0]         lut_in,
   output logic                    busy,
   output logic                    done,
   output logic [(1<<N_IN)-1:0]    truth,
   output logic                    pass,
   output logic [N_IN:0]           fail_count,
   output logic [N_IN-1:0]         first_fail
);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   // Settle counter compares against SETTLE_CYC-1; clamped so a zero
   // settle time still elaborates (SETTLE is never entered in that case).
   localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

   state_t                  state, state_next;
   logic [3:0]              settle_cnt;
   logic [(1<<N_IN)-1:0]    exp_q;
   logic                    mismatch;
   logic                    last_vec;

   assign mismatch = (f_in != exp_q[lut_in]);
   assign last_vec = (lut_in == '1);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (SETTLE_CYC > 0) state_next = SETTLE;
               else                state_next = SAMPLE;
            end
         end
         SETTLE: begin
            busy = 1'b1;
            if (settle_cnt == SETTLE_LAST) state_next = SAMPLE;
         end
         SAMPLE: begin
            busy = 1'b1;
            if (last_vec)            state_next = DONE;
            else if (SETTLE_CYC > 0) state_next = SETTLE;
            else                     state_next = SAMPLE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
         exp_q      <= '0;
         lut_in     <= '0;
         truth      <= '0;
         pass       <= 1'b0;
         fail_count <= '0;
         first_fail <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  exp_q      <= expected;
                  truth      <= '0;
                  pass       <= 1'b0;
                  fail_count <= '0;
                  first_fail <= '0;
                  lut_in     <= '0;
                  settle_cnt <= '0;
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) settle_cnt <= '0;
               else                           settle_cnt <= settle_cnt + 4'd1;
            end
            SAMPLE: begin
               truth[lut_in] <= f_in;
               if (mismatch) begin
                  fail_count <= fail_count + 1'b1;
                  if (fail_count == '0) first_fail <= lut_in;
               end
               // pass is resolved on the final sample edge so that it is
               // already valid during the done cycle.
               if (last_vec) pass <= (fail_count == '0) && !mismatch;
               else          lut_in <= lut_in + 1'b1;
            end
            DONE: begin
               lut_in <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lut_sweep_ctrl.sv
module tb_lut_sweep_ctrl;

   localparam int LA = 24;   // 8 vectors * 3 cycles
   localparam int LB = 4;    // 4 vectors * 1 cycle

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       start_a = 1'b1, start_b = 1'b1;
   logic [7:0] expected_a = 8'h00, ftab_a = 8'hE8;
   logic [3:0] expected_b = 4'h0,  ftab_b = 4'h6;
   logic       f_in_a, f_in_b;

   logic [2:0] lut_in_a; logic busy_a, done_a; logic [7:0] truth_a;
   logic pass_a; logic [3:0] fc_a; logic [2:0] ff_a;
   logic [1:0] lut_in_b; logic busy_b, done_b; logic [3:0] truth_b;
   logic pass_b; logic [2:0] fc_b; logic [1:0] ff_b;

   assign f_in_a = ftab_a[lut_in_a];
   assign f_in_b = ftab_b[lut_in_b];

   lut_sweep_ctrl #(.N_IN(3), .SETTLE_CYC(2)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .expected(expected_a), .f_in(f_in_a),
      .lut_in(lut_in_a), .busy(busy_a), .done(done_a), .truth(truth_a),
      .pass(pass_a), .fail_count(fc_a), .first_fail(ff_a));

   lut_sweep_ctrl #(.N_IN(2), .SETTLE_CYC(0)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .expected(expected_b), .f_in(f_in_b),
      .lut_in(lut_in_b), .busy(busy_b), .done(done_b), .truth(truth_b),
      .pass(pass_b), .fail_count(fc_b), .first_fail(ff_b));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout t=%0t", name, $time);
   endtask

   // Reference: outputs as a function of cycles elapsed since the sweep
   // was accepted (t=0 is the first busy cycle).
   function automatic void model(input int nin, input int s, input bit started, input int t,
                                 input logic [63:0] ex, input logic [63:0] ft,
                                 output logic [63:0] lut, output logic [63:0] bsy,
                                 output logic [63:0] dn, output logic [63:0] tr,
                                 output logic [63:0] ps, output logic [63:0] fc,
                                 output logic [63:0] ff);
      int depth, len, cnt, nfail;
      bit seen;
      depth = 1 << nin;
      len   = depth * (s + 1);
      lut = '0; bsy = '0; dn = '0; tr = '0; ps = '0; fc = '0; ff = '0;
      if (!started) return;
      if (t < len) begin
         bsy = 64'd1;
         cnt = t / (s + 1);
         lut = 64'(cnt);
      end else begin
         cnt = depth;
         dn  = 64'(t == len);
         lut = (t == len) ? 64'(depth - 1) : 64'd0;
      end
      nfail = 0;
      seen  = 1'b0;
      for (int i = 0; i < cnt; i++) begin
         tr[i] = ft[i];
         if (ft[i] !== ex[i]) begin
            nfail++;
            if (!seen) begin ff = 64'(i); seen = 1'b1; end
         end
      end
      fc = 64'(nfail);
      ps = 64'(t >= len && nfail == 0);
   endfunction

   bit a_started = 0, b_started = 0;
   int a_t = 0, b_t = 0;
   logic [7:0] a_ex, a_ft;
   logic [3:0] b_ex, b_ft;

   always @(posedge clk) begin
      if (rst) begin
         a_started = 0; a_t = 0;
      end else if (start_a && (!a_started || a_t > LA)) begin
         a_started = 1; a_t = 0; a_ex = expected_a; a_ft = ftab_a;
      end else if (a_started && a_t <= LA) a_t++;
   end

   always @(posedge clk) begin
      if (rst) begin
         b_started = 0; b_t = 0;
      end else if (start_b && (!b_started || b_t > LB)) begin
         b_started = 1; b_t = 0; b_ex = expected_b; b_ft = ftab_b;
      end else if (b_started && b_t <= LB) b_t++;
   end

   always @(negedge clk) begin : cmp_a
      logic [63:0] l, b, d, tr, p, f, ff;
      model(3, 2, a_started, a_t, 64'(a_ex), 64'(a_ft), l, b, d, tr, p, f, ff);
      chk("a_lut_in", 64'(lut_in_a), l);
      chk("a_busy", 64'(busy_a), b);
      chk("a_done", 64'(done_a), d);
      chk("a_truth", 64'(truth_a), tr);
      chk("a_pass", 64'(pass_a), p);
      chk("a_fail_count", 64'(fc_a), f);
      chk("a_first_fail", 64'(ff_a), ff);
   end

   always @(negedge clk) begin : cmp_b
      logic [63:0] l, b, d, tr, p, f, ff;
      model(2, 0, b_started, b_t, 64'(b_ex), 64'(b_ft), l, b, d, tr, p, f, ff);
      chk("b_lut_in", 64'(lut_in_b), l);
      chk("b_busy", 64'(busy_b), b);
      chk("b_done", 64'(done_b), d);
      chk("b_truth", 64'(truth_b), tr);
      chk("b_pass", 64'(pass_b), p);
      chk("b_fail_count", 64'(fc_b), f);
      chk("b_first_fail", 64'(ff_b), ff);
   end

   // Directed sweep on instance A with literal result expectations.
   // inj_at >= 0 pulses start and changes expected at that busy cycle.
   task automatic sweep_a(input logic [7:0] ex, input int inj_at, input logic [7:0] inj_ex,
                          input logic [7:0] w_truth, input bit w_pass,
                          input int w_fc, input int w_ff);
      int nb;
      bit got;
      nb = 0; got = 0;
      @(negedge clk); expected_a = ex; start_a = 1'b1;
      @(negedge clk); start_a = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (k == inj_at) begin start_a = 1'b1; expected_a = inj_ex; end
         if (k == inj_at + 1) start_a = 1'b0;
         if (done_a) begin got = 1; break; end
         if (busy_a) nb++;
         @(negedge clk);
      end
      if (!got) timeout("a_sweep_done");
      else begin
         chk("a_lit_busy_len", 64'(nb), 64'(LA));
         chk("a_lit_lut_final", 64'(lut_in_a), 64'd7);
         chk("a_lit_truth", 64'(truth_a), 64'(w_truth));
         chk("a_lit_pass", 64'(pass_a), 64'(w_pass));
         chk("a_lit_fail_count", 64'(fc_a), 64'(w_fc));
         chk("a_lit_first_fail", 64'(ff_a), 64'(w_ff));
         @(negedge clk);
         chk("a_lit_done_pulse", 64'(done_a), 64'd0);
         chk("a_lit_lut_idle", 64'(lut_in_a), 64'd0);
         chk("a_lit_pass_hold", 64'(pass_a), 64'(w_pass));
      end
   endtask

   initial begin
      // reset with start held high
      repeat (2) @(negedge clk);
      chk("rst_busy_a", 64'(busy_a), 64'd0);
      chk("rst_truth_a", 64'(truth_a), 64'd0);
      chk("rst_busy_b", 64'(busy_b), 64'd0);
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      repeat (2) @(negedge clk);

      ftab_a = 8'hE8;   // majority(A,B,C)
      sweep_a(8'hE8, -10, 8'h00, 8'hE8, 1'b1, 0, 0);
      sweep_a(8'hE9, -10, 8'h00, 8'hE8, 1'b0, 1, 0);
      sweep_a(8'h17, -10, 8'h00, 8'hE8, 1'b0, 8, 0);
      sweep_a(8'hE0, -10, 8'h00, 8'hE8, 1'b0, 1, 3);
      // restart attempt and expected change mid-sweep are ignored
      sweep_a(8'hE8, 5, 8'h17, 8'hE8, 1'b1, 0, 0);

      // reset mid-sweep while lut_in = 4
      begin : mid_rst
         bit hit;
         int dn;
         hit = 0; dn = 0;
         @(negedge clk); expected_a = 8'hE0; start_a = 1'b1;
         @(negedge clk); start_a = 1'b0;
         for (int k = 0; k < 100; k++) begin
            if (lut_in_a == 3'd4) begin hit = 1; break; end
            @(negedge clk);
         end
         if (!hit) timeout("a_reach_lut4");
         rst = 1'b1;
         @(negedge clk); rst = 1'b0;
         chk("a_lit_rst_lut", 64'(lut_in_a), 64'd0);
         chk("a_lit_rst_busy", 64'(busy_a), 64'd0);
         chk("a_lit_rst_truth", 64'(truth_a), 64'd0);
         chk("a_lit_rst_fc", 64'(fc_a), 64'd0);
         for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_a) dn++;
         end
         chk("a_lit_no_done", 64'(dn), 64'd0);
      end
      sweep_a(8'hE8, -10, 8'h00, 8'hE8, 1'b1, 0, 0);

      // instance B: N_IN=2, no settle, F = A^B
      begin : dir_b
         int nb;
         bit got;
         nb = 0; got = 0;
         ftab_b = 4'h6;
         @(negedge clk); expected_b = 4'h6; start_b = 1'b1;
         @(negedge clk); start_b = 1'b0;
         for (int k = 0; k < 50; k++) begin
            if (done_b) begin got = 1; break; end
            if (busy_b) nb++;
            @(negedge clk);
         end
         if (!got) timeout("b_sweep_done");
         else begin
            chk("b_lit_busy_len", 64'(nb), 64'(LB));
            chk("b_lit_truth", 64'(truth_b), 64'h6);
            chk("b_lit_pass", 64'(pass_b), 64'd1);
            chk("b_lit_lut_final", 64'(lut_in_b), 64'd3);
         end
      end

      // randomized traffic on both instances
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         rst     = ($urandom_range(0, 149) == 0);
         start_a = ($urandom_range(0, 5) == 0);
         start_b = ($urandom_range(0, 3) == 0);
         if (!a_started || a_t > LA) begin
            if ($urandom_range(0, 3) == 0) ftab_a = 8'($urandom);
         end
         if (!b_started || b_t > LB) begin
            if ($urandom_range(0, 3) == 0) ftab_b = 4'($urandom);
         end
         case ($urandom_range(0, 3))
            0: expected_a = ftab_a;
            1: expected_a = ftab_a ^ (8'd1 << $urandom_range(0, 7));
            default: expected_a = 8'($urandom);
         endcase
         case ($urandom_range(0, 2))
            0: expected_b = ftab_b;
            1: expected_b = ftab_b ^ (4'd1 << $urandom_range(0, 3));
            default: expected_b = 4'($urandom);
         endcase
      end
      @(posedge clk); #1;
      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
